apb_master_bridge_p: RTL and testbench

Parametrised APB master bridge: accepts single read/write requests on the user-side `transfer` interface and executes them as APB transfers to one of `NUM_SLAVES` completers. Its generalisations are:
- configurable address and data width;
- byte strobes and protection attributes;
- wait-state support through PREADY;
- an access timeout;
- registered request capture, so the user no longer holds inputs stable.

It sits between the testbench/user driver and the APB slave fabric.

---
 rtl/apb_bridge_pkg.sv | 26 ++
 rtl/apb_slave_decoder.sv | 33 +++
 rtl/apb_master_bridge_p.sv | 163 ++++++++++++++++
 tb/tb_apb_master_bridge_p.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// apb_bridge_pkg: shared types and constants for the APB master bridge.
// Holds the FSM state enum, PPROT bit positions and direction encodings.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DERR   = 2'd3
    } apb_state_e;

    // PPROT bit positions
    localparam int PROT_PRIV   = 0;
    localparam int PROT_NONSEC = 1;
    localparam int PROT_INSTR  = 2;

    // READ_WRITE encodings
    localparam logic DIR_READ  = 1'b1;
    localparam logic DIR_WRITE = 1'b0;

    // Width of a slave index; never below one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// apb_slave_decoder: maps the top address bits to a one-hot completer select.
// Ports: addr (in), sel (one-hot out), dec_err (out, index has no completer).
module apb_slave_decoder
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_SLAVES = 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  dec_err
);

    localparam int SEL_W = sel_width(NUM_SLAVES);

    logic [SEL_W-1:0] idx;
    logic             unused_addr;

    assign idx = addr[ADDR_WIDTH-1 -: SEL_W];

    // Low address bits belong to the completer, not to the decode.
    assign unused_addr = &{1'b0, addr};

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel[i] = (idx == SEL_W'(i));
        end
        // Index past the last completer selects nothing.
        dec_err = ~|sel;
    end

endmodule

// File: rtl/apb_master_bridge_p.sv
// apb_master_bridge_p: registered single-request APB master with timeout.
// Ports: user side transfer/req_ready/READ_WRITE/addresses/data/strb/prot,
// response rsp_valid/apb_read_data_out/PSLVERR, APB side PADDR..PENABLE,
// and per-completer s_prdata/s_pready/s_pslverr.
module apb_master_bridge_p
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_SLAVES     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,

    input  logic                             transfer,
    output logic                             req_ready,
    input  logic                             READ_WRITE,
    input  logic [ADDR_WIDTH-1:0]            apb_write_paddr,
    input  logic [ADDR_WIDTH-1:0]            apb_read_paddr,
    input  logic [DATA_WIDTH-1:0]            apb_write_data,
    input  logic [DATA_WIDTH/8-1:0]          apb_wstrb,
    input  logic [2:0]                       apb_prot,

    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            apb_read_data_out,
    output logic                             PSLVERR,

    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    output logic [DATA_WIDTH/8-1:0]          PSTRB,
    output logic [2:0]                       PPROT,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,

    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_prdata,
    input  logic [NUM_SLAVES-1:0]            s_pready,
    input  logic [NUM_SLAVES-1:0]            s_pslverr
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int TW =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam bit T_EN = (TIMEOUT_CYCLES != 0);

    apb_state_e state;

    logic [TW-1:0]         tcnt;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_err;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;

    assign req_ready = (state == IDLE);
    assign rd_req    = (READ_WRITE == DIR_READ);
    assign req_addr  = rd_req ? apb_read_paddr : apb_write_paddr;

    apb_slave_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES)
    ) u_dec (
        .addr    (req_addr),
        .sel     (dec_sel),
        .dec_err (dec_err)
    );

    // PSEL is one-hot while a transfer is live, so masking with it
    // discards whatever unselected completers drive.
    assign sel_ready = |(s_pready & PSEL);
    assign sel_err   = |(s_pslverr & PSEL);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (PSEL[i]) begin
                sel_rdata = sel_rdata
                          | s_prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state             <= IDLE;
            tcnt              <= '0;
            PADDR             <= '0;
            PWRITE            <= 1'b0;
            PWDATA            <= '0;
            PSTRB             <= '0;
            PPROT             <= '0;
            PSEL              <= '0;
            PENABLE           <= 1'b0;
            rsp_valid         <= 1'b0;
            apb_read_data_out <= '0;
            PSLVERR           <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (transfer) begin
                        PADDR  <= req_addr;
                        PWRITE <= (READ_WRITE == DIR_WRITE);
                        PPROT  <= apb_prot;
                        // Reads never drive write data or strobes.
                        PWDATA <= rd_req ? '0 : apb_write_data;
                        PSTRB  <= rd_req ? STRB_W'(0) : apb_wstrb;
                        if (dec_err) begin
                            PSEL  <= '0;
                            state <= DERR;
                        end else begin
                            PSEL  <= dec_sel;
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    tcnt    <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // A ready completer wins over a same-edge timeout.
                    if (sel_ready) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        PSLVERR   <= sel_err;
                        if (!PWRITE) begin
                            apb_read_data_out <= sel_rdata;
                        end
                        state <= IDLE;
                    end else if (T_EN && tcnt == T_LAST) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        PSLVERR   <= 1'b1;
                        if (!PWRITE) begin
                            apb_read_data_out <= '0;
                        end
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DERR: begin
                    rsp_valid <= 1'b1;
                    PSLVERR   <= 1'b1;
                    if (!PWRITE) begin
                        apb_read_data_out <= '0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge_p.sv
// tb_apb_master_bridge_p: scoreboard bench for the APB master bridge.
// Two instances: 2 completers for the main flows, 3 for decode errors.
module tb_apb_master_bridge_p;

    typedef struct {
        logic [7:0] rd;
        logic       err;
        int         due;
    } exp_t;

    logic PCLK;
    logic PRESETn;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    exp_t qa[$];
    exp_t qb[$];

    // instance A signals
    logic        a_transfer, a_ready, a_rw;
    logic [8:0]  a_waddr, a_raddr, a_paddr;
    logic [7:0]  a_wdata, a_rdata, a_pwdata;
    logic        a_wstrb, a_pstrb;
    logic [2:0]  a_prot, a_pprot;
    logic        a_rsp, a_err, a_pwrite, a_penable;
    logic [1:0]  a_psel, a_pready, a_pslverr;
    logic [15:0] a_prdata;

    // instance B signals
    logic        b_transfer, b_ready, b_rw;
    logic [8:0]  b_waddr, b_raddr, b_paddr;
    logic [7:0]  b_wdata, b_rdata, b_pwdata;
    logic        b_wstrb, b_pstrb;
    logic [2:0]  b_prot, b_pprot;
    logic        b_rsp, b_err, b_pwrite, b_penable;
    logic [2:0]  b_psel, b_pready, b_pslverr;
    logic [23:0] b_prdata;

    // completer model controls for instance A
    int         wait_n;
    int         wcnt;
    bit         hang;
    logic       err_cfg;
    logic [7:0] rd0;
    logic       rdy;

    apb_master_bridge_p #(
        .ADDR_WIDTH(9), .DATA_WIDTH(8),
        .NUM_SLAVES(2), .TIMEOUT_CYCLES(4)
    ) dut_a (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .transfer(a_transfer), .req_ready(a_ready),
        .READ_WRITE(a_rw),
        .apb_write_paddr(a_waddr), .apb_read_paddr(a_raddr),
        .apb_write_data(a_wdata), .apb_wstrb(a_wstrb),
        .apb_prot(a_prot),
        .rsp_valid(a_rsp), .apb_read_data_out(a_rdata),
        .PSLVERR(a_err),
        .PADDR(a_paddr), .PWRITE(a_pwrite), .PWDATA(a_pwdata),
        .PSTRB(a_pstrb), .PPROT(a_pprot), .PSEL(a_psel),
        .PENABLE(a_penable),
        .s_prdata(a_prdata), .s_pready(a_pready),
        .s_pslverr(a_pslverr)
    );

    apb_master_bridge_p #(
        .ADDR_WIDTH(9), .DATA_WIDTH(8),
        .NUM_SLAVES(3), .TIMEOUT_CYCLES(4)
    ) dut_b (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .transfer(b_transfer), .req_ready(b_ready),
        .READ_WRITE(b_rw),
        .apb_write_paddr(b_waddr), .apb_read_paddr(b_raddr),
        .apb_write_data(b_wdata), .apb_wstrb(b_wstrb),
        .apb_prot(b_prot),
        .rsp_valid(b_rsp), .apb_read_data_out(b_rdata),
        .PSLVERR(b_err),
        .PADDR(b_paddr), .PWRITE(b_pwrite), .PWDATA(b_pwdata),
        .PSTRB(b_pstrb), .PPROT(b_pprot), .PSEL(b_psel),
        .PENABLE(b_penable),
        .s_prdata(b_prdata), .s_pready(b_pready),
        .s_pslverr(b_pslverr)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    always @(posedge PCLK) cyc <= cyc + 1;

    // Completer model A: selected slave is ready after wait_n ACCESS
    // cycles; unselected slaves drive ready/error high as bait.
    always @(posedge PCLK) wcnt <= a_penable ? wcnt + 1 : 0;

    always_comb begin
        rdy       = a_penable && !hang && (wcnt >= wait_n);
        a_pready  = '1;
        a_pslverr = '1;
        for (int i = 0; i < 2; i++) begin
            if (a_psel[i]) begin
                a_pready[i]  = rdy;
                a_pslverr[i] = err_cfg;
            end
        end
    end

    assign a_prdata  = {8'h3C, rd0};
    assign b_pready  = 3'b111;
    assign b_pslverr = 3'b000;
    assign b_prdata  = 24'h332211;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Response monitors: pop and compare on every rsp_valid pulse.
    always @(negedge PCLK) begin
        exp_t e;
        if (a_rsp) begin
            if (qa.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL a_spurious_rsp: got rsp_valid 1 expected 0");
            end else begin
                e = qa.pop_front();
                chk("a_rdata", 32'(a_rdata), 32'(e.rd));
                chk("a_pslverr", 32'(a_err), 32'(e.err));
                chk("a_latency", cyc, e.due);
                chk("a_psel_after", 32'(a_psel), 0);
            end
        end
        if (b_rsp) begin
            if (qb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b_spurious_rsp: got rsp_valid 1 expected 0");
            end else begin
                e = qb.pop_front();
                chk("b_rdata", 32'(b_rdata), 32'(e.rd));
                chk("b_pslverr", 32'(b_err), 32'(e.err));
                chk("b_latency", cyc, e.due);
            end
        end
    end

    task automatic issue(input bit on_b, input logic rw,
                         input logic [8:0] adr, input logic [7:0] wd,
                         input logic st, input logic [2:0] pr,
                         input bit push, input logic [7:0] erd,
                         input logic eerr, input int lat);
        int   g;
        exp_t e;
        g = 0;
        @(negedge PCLK);
        while (!(on_b ? b_ready : a_ready) && g < 40) begin
            @(negedge PCLK);
            g++;
        end
        chk("req_ready_wait", 32'(on_b ? b_ready : a_ready), 1);
        if (on_b) begin
            b_rw = rw; b_wdata = wd; b_wstrb = st; b_prot = pr;
            b_waddr = rw ? ~adr : adr;
            b_raddr = rw ? adr : ~adr;
            b_transfer = 1'b1;
        end else begin
            a_rw = rw; a_wdata = wd; a_wstrb = st; a_prot = pr;
            a_waddr = rw ? ~adr : adr;
            a_raddr = rw ? adr : ~adr;
            a_transfer = 1'b1;
        end
        @(posedge PCLK);
        #1;
        e.rd  = erd;
        e.err = eerr;
        e.due = cyc + lat - 1;
        if (push) begin
            if (on_b) qb.push_back(e);
            else qa.push_back(e);
        end
        // Disturb every input; captured values must not follow.
        if (on_b) begin
            b_transfer = 1'b0; b_rw = ~b_rw;
            b_waddr = ~b_waddr; b_raddr = ~b_raddr;
            b_wdata = ~b_wdata; b_wstrb = ~b_wstrb; b_prot = ~b_prot;
        end else begin
            a_transfer = 1'b0; a_rw = ~a_rw;
            a_waddr = ~a_waddr; a_raddr = ~a_raddr;
            a_wdata = ~a_wdata; a_wstrb = ~a_wstrb; a_prot = ~a_prot;
        end
    endtask

    task automatic wait_done(input bit on_b);
        int g;
        g = 0;
        while ((on_b ? qb.size() : qa.size()) != 0 && g < 40) begin
            @(negedge PCLK);
            g++;
        end
        chk(on_b ? "b_rsp_wait" : "a_rsp_wait",
            on_b ? qb.size() : qa.size(), 0);
        if (on_b) qb.delete();
        else qa.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int g;
        n_cmp = 0; n_bad = 0; cyc = 0;
        PRESETn = 1'b0;
        a_transfer = 0; a_rw = 0; a_waddr = 0; a_raddr = 0;
        a_wdata = 0; a_wstrb = 0; a_prot = 0;
        b_transfer = 0; b_rw = 0; b_waddr = 0; b_raddr = 0;
        b_wdata = 0; b_wstrb = 0; b_prot = 0;
        wait_n = 0; hang = 0; err_cfg = 0; rd0 = 8'h5A;
        repeat (3) @(negedge PCLK);
        PRESETn = 1'b1;

        // reset state
        chk("rst_psel", 32'(a_psel), 0);
        chk("rst_penable", 32'(a_penable), 0);
        chk("rst_paddr", 32'(a_paddr), 0);
        chk("rst_pwrite", 32'(a_pwrite), 0);
        chk("rst_pwdata", 32'(a_pwdata), 0);
        chk("rst_pstrb", 32'(a_pstrb), 0);
        chk("rst_pprot", 32'(a_pprot), 0);
        chk("rst_rsp", 32'(a_rsp), 0);
        chk("rst_rdata", 32'(a_rdata), 0);
        chk("rst_pslverr", 32'(a_err), 0);
        chk("rst_ready", 32'(a_ready), 1);
        chk("rst_b_psel", 32'(b_psel), 0);

        // zero-wait write to slave 0
        issue(0, 1'b0, 9'h005, 8'hA5, 1'b1, 3'b010,
              1, 8'h00, 1'b0, 3);
        @(negedge PCLK);
        chk("wr_setup_psel", 32'(a_psel), 32'h1);
        chk("wr_setup_penable", 32'(a_penable), 0);
        chk("wr_pwdata", 32'(a_pwdata), 32'hA5);
        chk("wr_pprot", 32'(a_pprot), 2);
        chk("wr_pstrb", 32'(a_pstrb), 1);
        chk("wr_paddr", 32'(a_paddr), 32'h005);
        chk("wr_pwrite", 32'(a_pwrite), 1);
        @(negedge PCLK);
        chk("wr_access_penable", 32'(a_penable), 1);
        chk("wr_access_paddr", 32'(a_paddr), 32'h005);
        wait_done(0);

        // read from slave 1 with two wait states
        wait_n = 2;
        issue(0, 1'b1, 9'h105, 8'hFF, 1'b1, 3'b001,
              1, 8'h3C, 1'b0, 5);
        @(negedge PCLK);
        chk("rd_pstrb", 32'(a_pstrb), 0);
        chk("rd_pwdata", 32'(a_pwdata), 0);
        chk("rd_pwrite", 32'(a_pwrite), 0);
        chk("rd_paddr", 32'(a_paddr), 32'h105);
        n = 0; g = 0;
        while (!a_rsp && g < 20) begin
            if (a_psel == 2'b10) n++;
            @(negedge PCLK);
            g++;
        end
        chk("rd_psel_cycles", n, 4);
        wait_done(0);

        // timeout: PREADY never rises, read data forced to 0
        wait_n = 0; hang = 1;
        issue(0, 1'b1, 9'h010, 8'h00, 1'b0, 3'b000,
              1, 8'h00, 1'b1, 6);
        wait_done(0);
        hang = 0;

        // PREADY on the timeout edge: completion wins
        wait_n = 3;
        issue(0, 1'b1, 9'h010, 8'h00, 1'b0, 3'b000,
              1, 8'h5A, 1'b0, 6);
        wait_done(0);

        // slave error on a write; read data must hold
        wait_n = 0; err_cfg = 1'b1;
        issue(0, 1'b0, 9'h020, 8'h33, 1'b1, 3'b000,
              1, 8'h5A, 1'b1, 3);
        wait_done(0);
        err_cfg = 1'b0;

        // reset in the middle of ACCESS
        hang = 1;
        issue(0, 1'b1, 9'h030, 8'h00, 1'b0, 3'b000,
              0, 8'h00, 1'b0, 0);
        g = 0;
        while (!a_penable && g < 10) begin
            @(negedge PCLK);
            g++;
        end
        chk("mid_reached_access", 32'(a_penable), 1);
        PRESETn = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        chk("mid_rst_psel", 32'(a_psel), 0);
        chk("mid_rst_penable", 32'(a_penable), 0);
        chk("mid_rst_rdata", 32'(a_rdata), 0);
        chk("mid_rst_pslverr", 32'(a_err), 0);
        chk("mid_rst_ready", 32'(a_ready), 1);
        hang = 0;
        repeat (6) @(negedge PCLK);

        // recovery read from slave 1
        issue(0, 1'b1, 9'h180, 8'h00, 1'b0, 3'b000,
              1, 8'h3C, 1'b0, 3);
        wait_done(0);

        // decode error on the 3-completer instance
        issue(1, 1'b0, 9'h1C0, 8'h77, 1'b1, 3'b100,
              1, 8'h00, 1'b1, 2);
        @(negedge PCLK);
        chk("derr_psel", 32'(b_psel), 0);
        chk("derr_penable", 32'(b_penable), 0);
        chk("derr_paddr", 32'(b_paddr), 32'h1C0);
        chk("derr_pwdata", 32'(b_pwdata), 32'h77);
        wait_done(1);

        issue(1, 1'b1, 9'h100, 8'h00, 1'b0, 3'b000,
              1, 8'h33, 1'b0, 3);
        @(negedge PCLK);
        chk("b_slave2_psel", 32'(b_psel), 32'h4);
        wait_done(1);

        issue(1, 1'b1, 9'h080, 8'h00, 1'b0, 3'b000,
              1, 8'h22, 1'b0, 3);
        @(negedge PCLK);
        chk("b_slave1_psel", 32'(b_psel), 32'h2);
        wait_done(1);

        repeat (3) @(negedge PCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
